// File: rtl/write_axi_arbiter_if.sv
// write_axi_arbiter_if: one AXI4 write port (AW, W and B channels) between a requester and the arbiter
interface write_axi_arbiter_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/write_axi_arbiter.sv
// write_axi_arbiter: shares one AXI write port between the dcache writeback (s0) and uncached stores (s1)
module write_axi_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    write_axi_arbiter_if.slave  s0,
    write_axi_arbiter_if.slave  s1,
    write_axi_arbiter_if.master m,
    output logic [1:0]         grant,
    output logic               err_wlast
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t     state;
    logic       last_s1;
    logic [7:0] beat_cnt;
    logic [7:0] beat_lim;
    logic       g1;
    logic       pick_s1;
    logic       aw_v;
    logic       w_v;
    logic       b_r;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;

    assign g1      = grant[1];
    assign pick_s1 = s1.awvalid && (!s0.awvalid || (RR_EN && !last_s1));
    assign aw_hs   = aw_v && m.awready;
    assign w_hs    = w_v && m.wready;
    assign b_hs    = b_r && m.bvalid;

    // Steer the granted requester onto the shared port; anything not owned by the current phase reads 0
    always_comb begin
        aw_v       = (state == ADDR) && (g1 ? s1.awvalid : s0.awvalid);
        w_v        = (state == DATA) && (g1 ? s1.wvalid : s0.wvalid);
        b_r        = (state == RESP) && (g1 ? s1.bready : s0.bready);
        m.awvalid  = aw_v;
        m.awaddr   = aw_v ? (g1 ? s1.awaddr : s0.awaddr) : '0;
        m.awlen    = aw_v ? (g1 ? s1.awlen : s0.awlen) : '0;
        m.awsize   = aw_v ? (g1 ? s1.awsize : s0.awsize) : '0;
        m.wvalid   = w_v;
        m.wdata    = w_v ? (g1 ? s1.wdata : s0.wdata) : '0;
        m.wstrb    = w_v ? (g1 ? s1.wstrb : s0.wstrb) : '0;
        m.wlast    = w_v ? (g1 ? s1.wlast : s0.wlast) : 1'b0;
        m.bready   = b_r;
        s0.awready = (state == ADDR) && grant[0] && m.awready;
        s1.awready = (state == ADDR) && grant[1] && m.awready;
        s0.wready  = (state == DATA) && grant[0] && m.wready;
        s1.wready  = (state == DATA) && grant[1] && m.wready;
        s0.bvalid  = (state == RESP) && grant[0] && m.bvalid;
        s1.bvalid  = (state == RESP) && grant[1] && m.bvalid;
    end

    // Arbitrate in IDLE, then carry the owner through its AW, W and B handshakes before releasing the port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            grant     <= '0;
            last_s1   <= 1'b1;
            beat_cnt  <= '0;
            beat_lim  <= '0;
            err_wlast <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s0.awvalid || s1.awvalid) begin
                    grant <= {pick_s1, !pick_s1};
                    state <= ADDR;
                end
                ADDR: if (aw_hs) begin
                    beat_lim <= m.awlen;
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: if (w_hs) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (m.wlast != (beat_cnt == beat_lim)) err_wlast <= 1'b1;
                    if (m.wlast) state <= RESP;
                end
                RESP: if (b_hs) begin
                    last_s1 <= grant[1];
                    grant   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_write_axi_arbiter.sv
// tb_write_axi_arbiter: directed checks of the write arbiter (round-robin and fixed-priority builds)
module tb_write_axi_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rstn_fp = 1'b0;
    logic [1:0] grant;
    logic [1:0] fgrant;
    logic err_wlast;
    logic ferr;
    int n_tests = 0;
    int n_fail = 0;
    int aw_cnt = 0;
    int b_cnt = 0;
    logic [31:0] beats[$];

    always #5 clk = ~clk;

    write_axi_arbiter_if s0();
    write_axi_arbiter_if s1();
    write_axi_arbiter_if m();
    write_axi_arbiter_if fs0();
    write_axi_arbiter_if fs1();
    write_axi_arbiter_if fm();

    write_axi_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn), .s0(s0), .s1(s1), .m(m), .grant(grant), .err_wlast(err_wlast)
    );

    write_axi_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .resetn(rstn_fp), .s0(fs0), .s1(fs1), .m(fm), .grant(fgrant), .err_wlast(ferr)
    );

    // Log every handshake on the shared port of the round-robin instance
    always @(posedge clk) begin
        if (m.awvalid && m.awready) aw_cnt++;
        if (m.wvalid && m.wready) beats.push_back(m.wdata);
        if (m.bvalid && m.bready) b_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_aw(input bit who, input logic [31:0] addr, input logic [7:0] len, input logic v);
        if (who) begin
            s1.awaddr  = addr;
            s1.awlen   = len;
            s1.awsize  = 3'd2;
            s1.awvalid = v;
        end else begin
            s0.awaddr  = addr;
            s0.awlen   = len;
            s0.awsize  = 3'd2;
            s0.awvalid = v;
        end
    endtask

    task automatic set_w(input bit who, input logic [31:0] data, input logic [3:0] strb, input logic last, input logic v);
        if (who) begin
            s1.wdata  = data;
            s1.wstrb  = strb;
            s1.wlast  = last;
            s1.wvalid = v;
        end else begin
            s0.wdata  = data;
            s0.wstrb  = strb;
            s0.wlast  = last;
            s0.wvalid = v;
        end
    endtask

    task automatic set_bready(input bit who, input logic v);
        if (who) s1.bready = v;
        else s0.bready = v;
    endtask

    function automatic logic awready_of(input bit who);
        return who ? s1.awready : s0.awready;
    endfunction

    function automatic logic wready_of(input bit who);
        return who ? s1.wready : s0.wready;
    endfunction

    function automatic logic bvalid_of(input bit who);
        return who ? s1.bvalid : s0.bvalid;
    endfunction

    // One full write from requester `who`; beat i carries addr+i, wlast on beat last_beat, optional wready stall
    task automatic do_write(input bit who, input logic [31:0] addr, input logic [7:0] len,
                            input int last_beat, input int stall_beat, input int stall_cyc);
        int n;
        set_aw(who, addr, len, 1'b1);
        set_bready(who, 1'b1);
        m.awready = 1'b1;
        m.wready  = 1'b1;
        m.bvalid  = 1'b0;
        n = 0;
        #1;
        while (!awready_of(who) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("aw_ready", awready_of(who), 1'b1);
        @(negedge clk);
        set_aw(who, 32'h0, 8'h0, 1'b0);
        for (int i = 0; i <= last_beat; i++) begin
            set_w(who, addr + 32'(i), 4'hF, i == last_beat, 1'b1);
            if (i == stall_beat) begin
                m.wready = 1'b0;
                repeat (stall_cyc) @(negedge clk);
                m.wready = 1'b1;
            end
            n = 0;
            #1;
            while (!wready_of(who) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("w_ready", wready_of(who), 1'b1);
            @(negedge clk);
        end
        set_w(who, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("resp_entry_bready", m.bready, 1'b1);
        m.bvalid = 1'b1;
        #1;
        check("b_valid", bvalid_of(who), 1'b1);
        @(negedge clk);
        m.bvalid = 1'b0;
        set_bready(who, 1'b0);
        #1;
        check("grant_after_b", grant, 2'b00);
    endtask

    initial begin
        int base;
        int bbase;
        logic [1:0] prev_rr;
        logic [1:0] prev_fp;
        logic [1:0] seq_rr [3];
        logic [1:0] seq_fp [3];
        int nr;
        int nf;
        for (int w = 0; w < 2; w++) begin
            set_aw(w[0], 32'h0, 8'h0, 1'b0);
            set_w(w[0], 32'h0, 4'h0, 1'b0, 1'b0);
            set_bready(w[0], 1'b0);
        end
        m.awready = 1'b0;
        m.wready  = 1'b0;
        m.bvalid  = 1'b0;
        fs0.awaddr = 32'h100; fs0.awlen = 8'h0; fs0.awsize = 3'd2; fs0.awvalid = 1'b1;
        fs0.wdata = 32'h1; fs0.wstrb = 4'hF; fs0.wlast = 1'b1; fs0.wvalid = 1'b1; fs0.bready = 1'b1;
        fs1.awaddr = 32'h200; fs1.awlen = 8'h0; fs1.awsize = 3'd2; fs1.awvalid = 1'b1;
        fs1.wdata = 32'h2; fs1.wstrb = 4'hF; fs1.wlast = 1'b1; fs1.wvalid = 1'b1; fs1.bready = 1'b1;
        fm.awready = 1'b1; fm.wready = 1'b1; fm.bvalid = 1'b1;
        // reset holds everything idle even with a request pending and the clock running
        s0.awvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_err", err_wlast, 1'b0);
        check("rst_awvalid", m.awvalid, 1'b0);
        check("rst_s0_awready", s0.awready, 1'b0);
        @(negedge clk);
        s0.awvalid = 1'b0;
        resetn = 1'b1;
        // single uncached store from s1
        @(negedge clk);
        base = beats.size();
        set_aw(1'b1, 32'h1FC0_0010, 8'h0, 1'b1);
        set_w(1'b1, 32'hCAFE_0001, 4'b0011, 1'b1, 1'b1);
        set_bready(1'b1, 1'b1);
        #1;
        check("st_idle_grant", grant, 2'b00);
        check("st_idle_awvalid", m.awvalid, 1'b0);
        @(negedge clk);
        #1;
        check("st_grant", grant, 2'b10);
        check("st_awvalid", m.awvalid, 1'b1);
        check("st_awaddr", m.awaddr, 32'h1FC0_0010);
        check("st_awready_held", s1.awready, 1'b0);
        check("st_wvalid_in_addr", m.wvalid, 1'b0);
        m.awready = 1'b1;
        #1;
        check("st_s1_awready", s1.awready, 1'b1);
        check("st_s0_awready", s0.awready, 1'b0);
        @(negedge clk);
        #1;
        m.awready = 1'b0;
        check("st_awvalid_in_data", m.awvalid, 1'b0);
        check("st_awaddr_zero", m.awaddr, 32'h0);
        check("st_wvalid", m.wvalid, 1'b1);
        check("st_wdata", m.wdata, 32'hCAFE_0001);
        check("st_wstrb", m.wstrb, 4'b0011);
        check("st_wlast", m.wlast, 1'b1);
        m.wready = 1'b1;
        #1;
        check("st_s1_wready", s1.wready, 1'b1);
        @(negedge clk);
        #1;
        m.wready = 1'b0;
        check("st_wvalid_in_resp", m.wvalid, 1'b0);
        check("st_wdata_zero", m.wdata, 32'h0);
        check("st_bready", m.bready, 1'b1);
        check("st_bvalid_wait", s1.bvalid, 1'b0);
        m.bvalid = 1'b1;
        #1;
        check("st_s1_bvalid", s1.bvalid, 1'b1);
        check("st_s0_bvalid", s0.bvalid, 1'b0);
        @(negedge clk);
        m.bvalid = 1'b0;
        set_aw(1'b1, 32'h0, 8'h0, 1'b0);
        set_w(1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
        set_bready(1'b1, 1'b0);
        #1;
        check("st_grant_done", grant, 2'b00);
        check("st_beats", beats.size() - base, 1);
        // four-beat line writeback with a two-cycle wready stall on beat 2
        @(negedge clk);
        base = beats.size();
        bbase = b_cnt;
        do_write(1'b0, 32'h0000_1000, 8'd3, 3, 2, 2);
        check("wb_beats", beats.size() - base, 4);
        for (int i = 0; i < 4; i++) check("wb_order", beats[base + i], 32'h1000 + 32'(i));
        check("wb_err", err_wlast, 1'b0);
        check("wb_b", b_cnt - bbase, 1);
        // awlen=3 but wlast on the second beat: early exit and sticky error
        @(negedge clk);
        base = beats.size();
        do_write(1'b0, 32'h0000_2000, 8'd3, 1, -1, 0);
        check("early_beats", beats.size() - base, 2);
        check("early_err", err_wlast, 1'b1);
        do_write(1'b1, 32'h0000_2100, 8'd1, 1, -1, 0);
        check("early_err_sticky", err_wlast, 1'b1);
        // reset pulsed during beat 2 of a four-beat burst
        @(negedge clk);
        base = beats.size();
        m.awready = 1'b1;
        m.wready  = 1'b1;
        set_aw(1'b0, 32'h0000_3000, 8'd3, 1'b1);
        set_bready(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        set_aw(1'b0, 32'h0, 8'h0, 1'b0);
        set_w(1'b0, 32'h3000, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        set_w(1'b0, 32'h3001, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        set_w(1'b0, 32'h3002, 4'hF, 1'b0, 1'b1);
        #1;
        check("mid_wvalid_pre", m.wvalid, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_wvalid", m.wvalid, 1'b0);
        check("mid_wready", s0.wready, 1'b0);
        check("mid_grant", grant, 2'b00);
        check("mid_bready", m.bready, 1'b0);
        check("mid_awvalid", m.awvalid, 1'b0);
        check("mid_err_cleared", err_wlast, 1'b0);
        set_w(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        set_bready(1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("mid_beats", beats.size() - base, 2);
        @(negedge clk);
        do_write(1'b1, 32'h0000_4000, 8'd0, 0, -1, 0);
        check("mid_after_beats", beats.size() - base, 3);
        check("mid_after_err", err_wlast, 1'b0);
        // both requesters streaming: round-robin alternates, fixed priority keeps s0
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        rstn_fp = 1'b1;
        set_aw(1'b0, 32'h100, 8'h0, 1'b1);
        set_aw(1'b1, 32'h200, 8'h0, 1'b1);
        set_w(1'b0, 32'h1, 4'hF, 1'b1, 1'b1);
        set_w(1'b1, 32'h2, 4'hF, 1'b1, 1'b1);
        set_bready(1'b0, 1'b1);
        set_bready(1'b1, 1'b1);
        m.awready = 1'b1;
        m.wready  = 1'b1;
        m.bvalid  = 1'b1;
        prev_rr = 2'b00;
        prev_fp = 2'b00;
        nr = 0;
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            seq_rr[i] = 2'b00;
            seq_fp[i] = 2'b00;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (grant != 2'b00 && prev_rr == 2'b00 && nr < 3) begin
                seq_rr[nr] = grant;
                nr++;
            end
            if (fgrant != 2'b00 && prev_fp == 2'b00 && nf < 3) begin
                seq_fp[nf] = fgrant;
                nf++;
            end
            if (grant == 2'b00) check("rr_idle_awvalid", m.awvalid, 1'b0);
            prev_rr = grant;
            prev_fp = fgrant;
        end
        check("rr_round0", seq_rr[0], 2'b01);
        check("rr_round1", seq_rr[1], 2'b10);
        check("rr_round2", seq_rr[2], 2'b01);
        check("fp_round0", seq_fp[0], 2'b01);
        check("fp_round1", seq_fp[1], 2'b01);
        check("fp_round2", seq_fp[2], 2'b01);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/write_axi_arbiter.md
WRITE_AXI_ARBITER -- requirements
Module: write_axi_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin between requesters, 0 = fixed priority with s0 always winning.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-004 sN_awaddr/sN_awlen/sN_awsize/sN_awvalid  input  32/8/3/1  write-address request from requester N (N=0 dcache writeback, N=1 uncached store).
REQ-005 sN_awready  output  1  address accepted for requester N.
REQ-006 sN_wdata/sN_wstrb/sN_wlast/sN_wvalid  input  32/4/1/1  write-data beat from requester N.
REQ-007 sN_wready  output  1  data beat accepted for requester N.
REQ-008 sN_bvalid  output  1  write response to requester N; sN_bready  input  1  requester N accepts the response.
REQ-009 m_awaddr/m_awlen/m_awsize/m_awvalid  output  32/8/3/1  shared AXI AW channel; m_awready  input  1.
REQ-010 m_wdata/m_wstrb/m_wlast/m_wvalid  output  32/4/1/1  shared AXI W channel; m_wready  input  1.
REQ-011 m_bvalid  input  1; m_bready  output  1  shared AXI B channel.
REQ-012 grant  output  2  one-hot owner of the shared port, 2'b00 when idle.
REQ-013 err_wlast  output  1  sticky flag, beat count and wlast disagree.

Function
REQ-014 The block SHALL implement a registered FSM with states IDLE, ADDR, DATA, RESP; exactly one write transaction owns the shared port from grant until its B handshake.
REQ-015 IDLE: if any sN_awvalid is high, the winner SHALL be latched into grant and the FSM SHALL move to ADDR on the next edge; no master output is valid in IDLE (1-cycle arbitration latency).
REQ-016 Arbitration with RR_EN=1: single requester wins; both requesting, the requester not granted last wins; last-grant pointer resets to 1 so s0 wins the first contest. RR_EN=0: s0 wins every contest.
REQ-017 ADDR: m_aw* SHALL be driven combinationally from the granted requester, sN_awready = m_awready for the granted N only; on m_awvalid & m_awready latch awlen into a beat limit, clear the 8-bit beat counter, go to DATA.
REQ-018 DATA: m_w* SHALL mirror the granted requester, sN_wready = m_wready for granted N only; each m_wvalid & m_wready handshake SHALL increment the beat counter.
REQ-019 DATA exit: a handshake with m_wlast=1 SHALL move the FSM to RESP; if that handshake occurs with counter != beat limit, or counter == beat limit without wlast, err_wlast SHALL set and remain set until reset.
REQ-020 RESP: sN_bvalid = m_bvalid for granted N, m_bready = sN_bready of granted N; on m_bvalid & m_bready update the last-grant pointer, clear grant, return to IDLE.
REQ-021 The non-granted requester SHALL see awready, wready and bvalid at 0 at all times; its pending awvalid SHALL be serviced in the IDLE cycle following the current transaction's B handshake.
REQ-022 Outside DATA, m_wvalid and all sN_wready SHALL be 0; outside RESP, m_bready and all sN_bvalid SHALL be 0; outside ADDR, m_awvalid and all sN_awready SHALL be 0.
REQ-023 Data outputs (m_awaddr, m_wdata, etc.) SHALL be 0 when their valid is 0.
REQ-024 A requester dropping awvalid after grant is a protocol violation; the block SHALL remain in ADDR until m_awready regardless.
REQ-025 Minimum back-to-back spacing: a new transaction's m_awvalid SHALL assert no earlier than two cycles after the previous B handshake.

Reset
REQ-026 While resetn=0, regardless of clock, the FSM SHALL be IDLE, grant=0, last-grant pointer=1, beat counter=0, err_wlast=0, and every valid/ready output SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately with no further beats or responses forwarded; after release the FSM SHALL arbitrate from IDLE.

Verification
REQ-028 Single uncached store: s1 awaddr=0x1FC0_0010, awlen=0, wstrb=4'b0011 -> grant=2'b10 one cycle later, one W beat with m_wlast=1, s1_bvalid on m_bvalid, grant=0 after B.
REQ-029 Line writeback: s0 awlen=3, four beats, m_wready stalled 2 cycles on beat 2 -> exactly four m_w handshakes, beat order preserved, err_wlast=0.
REQ-030 Simultaneous s0 and s1 awvalid, RR_EN=1, three rounds -> grants s0, s1, s0; with RR_EN=0 -> s0 each round while requesting.
REQ-031 s0 awlen=3 but wlast on beat 2 -> FSM enters RESP after beat 2, err_wlast=1 and stays 1 through later clean transactions.
REQ-032 resetn pulsed low during DATA beat 2 of a 4-beat burst -> all valids/readies 0 in same cycle, grant=0; next request granted normally after release.
